write_enable_sweep: RTL and testbench

- Parametrised write-enable sequencer for BRAM capture and averaging buffers.
- On `restart`, the block arms and waits for the free-running BRAM address counter to reach its last address.
- It then asserts `wen` for one or more gap-free full-depth sweeps, generating the write `count`, an `init` pulse near the end of each sweep, and a sweep index.
- Supports single-shot (N sweeps, then `done`) and continuous modes; it sits between the acquisition address counter and the BRAM write port and adder.

---
 rtl/write_enable_sweep.sv | 161 ++++++++++++++++
 tb/tb_write_enable_sweep.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_enable_sweep.sv
// ---------------------------------------------------------------------------
// write_enable_sweep
//
// Write-enable sequencer for BRAM capture and averaging buffers. After a
// restart request the block arms, waits for the free-running acquisition
// address counter to reach its last address, and then drives a gap-free
// write enable for one or more full-depth sweeps. Each sweep produces a
// write address (count), a one-cycle init marker a fixed number of cycles
// before the sweep ends, and a 0-based sweep index. In single-shot mode the
// block stops after N sweeps and pulses done; in continuous mode it keeps
// sweeping until the next restart.
//
// Ports
//   clk          in   1            rising-edge clock
//   aresetn      in   1            asynchronous active-low reset
//   restart      in   1            arm request (level, normally a pulse)
//   continuous   in   1            mode, sampled with restart
//   n_sweeps     in   SWEEP_WIDTH  sweeps per acquisition (0 acts as 1)
//   address      in   BRAM_WIDTH   free-running address used for alignment
//   wen          out  1            BRAM write enable
//   count        out  BRAM_WIDTH   write address inside the current sweep
//   init         out  1            one-cycle marker at count == LAST-INIT_LEAD
//   sweep_idx    out  SWEEP_WIDTH  current sweep number, 0-based
//   first_sweep  out  1            wen high during sweep 0
//   busy         out  1            armed or writing
//   done         out  1            one-cycle pulse after final single sweep
// ---------------------------------------------------------------------------
module write_enable_sweep #(
  parameter int unsigned BRAM_WIDTH  = 13,
  parameter int unsigned SWEEP_WIDTH = 16,
  parameter int unsigned INIT_LEAD   = 1
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   restart,
  input  logic                   continuous,
  input  logic [SWEEP_WIDTH-1:0] n_sweeps,
  input  logic [BRAM_WIDTH-1:0]  address,
  output logic                   wen,
  output logic [BRAM_WIDTH-1:0]  count,
  output logic                   init,
  output logic [SWEEP_WIDTH-1:0] sweep_idx,
  output logic                   first_sweep,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned           LAST_I       = (1 << BRAM_WIDTH) - 1;
  localparam logic [BRAM_WIDTH-1:0] LAST         = LAST_I[BRAM_WIDTH-1:0];
  localparam logic [BRAM_WIDTH-1:0] INIT_AT      = BRAM_WIDTH'(LAST_I - INIT_LEAD);
  // When the marker sits on count 0 it must be raised on the edge that
  // starts a sweep rather than on an ordinary increment.
  localparam logic                  INIT_AT_ZERO = (INIT_AT == '0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                 state;
  logic                   hit;       // address was LAST on the previous ARM edge
  logic                   cont_q;    // latched continuous mode
  logic [SWEEP_WIDTH-1:0] n_last;    // latched N-1, index of the final sweep
  logic [BRAM_WIDTH-1:0]  count_inc;

  assign count_inc = count + 1'b1;

  // NOTE: the async reset clears every register here, including the latched
  // mode and sweep count, so a reset mid-sweep drops all outputs at once and
  // can never leave a stale configuration behind for the next restart.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      hit         <= 1'b0;
      cont_q      <= 1'b0;
      n_last      <= '0;
      count       <= '0;
      sweep_idx   <= '0;
      wen         <= 1'b0;
      init        <= 1'b0;
      first_sweep <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later branches read the
      // pre-edge values of count/sweep_idx, which is what the sweep
      // arithmetic below relies on.
      done <= 1'b0;

      if (restart) begin
        // Restart wins over every other transition, including the final
        // count == LAST of a single-shot run, so no done is produced.
        state       <= ARM;
        hit         <= 1'b0;
        cont_q      <= continuous;
        n_last      <= (n_sweeps == '0) ? '0 : n_sweeps - 1'b1;
        wen         <= 1'b0;
        init        <= 1'b0;
        first_sweep <= 1'b0;
        busy        <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            // Hold count and sweep_idx from the last acquisition.
          end

          ARM: begin
            // The one-cycle hit register gives a two-cycle latency from
            // address == LAST to the first write, which lines count 0 up
            // with the address counter's wrap to 0 one cycle later.
            hit <= (address == LAST);
            if (hit) begin
              state       <= WRITE;
              count       <= '0;
              sweep_idx   <= '0;
              wen         <= 1'b1;
              first_sweep <= 1'b1;
              init        <= INIT_AT_ZERO;
            end
          end

          WRITE: begin
            if (count != LAST) begin
              count <= count_inc;
              init  <= (count_inc == INIT_AT);
            end else if (sweep_idx < n_last) begin
              count       <= '0;
              sweep_idx   <= sweep_idx + 1'b1;
              first_sweep <= 1'b0;
              init        <= INIT_AT_ZERO;
            end else if (cont_q) begin
              count       <= '0;
              sweep_idx   <= '0;
              first_sweep <= 1'b1;
              init        <= INIT_AT_ZERO;
            end else begin
              // Final single-shot sweep: count and sweep_idx keep their
              // last values until the next restart.
              state       <= IDLE;
              wen         <= 1'b0;
              init        <= 1'b0;
              first_sweep <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end
          end

          default: begin
            state       <= IDLE;
            wen         <= 1'b0;
            init        <= 1'b0;
            first_sweep <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_write_enable_sweep.sv
// ---------------------------------------------------------------------------
// tb_write_enable_sweep
//
// Scoreboard bench for write_enable_sweep (BRAM_WIDTH=4, INIT_LEAD=1).
// The driver applies directed and randomized restarts, modes, sweep counts
// and address glitches. Its reference model works in terms of whole
// acquisitions: once it sees address == LAST while armed it knows the write
// window starts two cycles later, and it derives every beat from the beat
// number j with plain division (count = j % 16, sweep = j / 16). Each
// expected beat or done pulse is queued with its cycle number; a separate
// monitor pops and compares whenever the DUT shows wen or done.
// ---------------------------------------------------------------------------
module tb_write_enable_sweep;

  localparam int BW   = 4;
  localparam int SW   = 16;
  localparam int LEAD = 1;
  localparam int SPAN = 1 << BW;
  localparam int LAST = SPAN - 1;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          restart;
  logic          continuous;
  logic [SW-1:0] n_sweeps;
  logic [BW-1:0] address;
  logic          wen;
  logic [BW-1:0] count;
  logic          init;
  logic [SW-1:0] sweep_idx;
  logic          first_sweep;
  logic          busy;
  logic          done;

  write_enable_sweep #(
    .BRAM_WIDTH (BW),
    .SWEEP_WIDTH(SW),
    .INIT_LEAD  (LEAD)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .restart    (restart),
    .continuous (continuous),
    .n_sweeps   (n_sweeps),
    .address    (address),
    .wen        (wen),
    .count      (count),
    .init       (init),
    .sweep_idx  (sweep_idx),
    .first_sweep(first_sweep),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit is_done;
    int e_count;
    int e_idx;
    bit e_init;
    bit e_first;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state (acquisition level).
  bit            scanning = 1'b0;
  bit            active   = 1'b0;
  bit            m_cont   = 1'b0;
  int            m_n      = 1;
  int            wstart   = 0;
  logic [BW-1:0] addr_fr  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called once per cycle after inputs are applied.
  task automatic model_update(input bit rs, input bit cont, input int n);
    int c;
    int j;
    exp_t e;
    c = cyc;
    if (rs) begin
      // Anything expected after this cycle is cancelled by the restart.
      while (sb.size() > 0 && sb[$].cyc > c) void'(sb.pop_back());
      active   = 1'b0;
      scanning = 1'b1;
      m_cont   = cont;
      m_n      = (n == 0) ? 1 : n;
    end else begin
      if (scanning && int'(address) == LAST) begin
        scanning = 1'b0;
        active   = 1'b1;
        wstart   = c + 2;
      end
      if (active) begin
        j = c + 2 - wstart;
        e.cyc = c + 2;
        if (m_cont || j < SPAN * m_n) begin
          e.is_done = 1'b0;
          e.e_count = j % SPAN;
          e.e_idx   = m_cont ? (j / SPAN) % m_n : j / SPAN;
          e.e_init  = (e.e_count == LAST - LEAD);
          e.e_first = (e.e_idx == 0);
          sb.push_back(e);
        end else begin
          e.is_done = 1'b1;
          e.e_count = LAST;
          e.e_idx   = m_n - 1;
          e.e_init  = 1'b0;
          e.e_first = 1'b0;
          sb.push_back(e);
          active = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input bit rs, input bit cont, input int n, input bit glitch);
    @(posedge clk);
    #1;
    addr_fr    = addr_fr + 1'b1;
    restart    = rs;
    continuous = cont;
    n_sweeps   = SW'(n);
    if (glitch && $urandom_range(7) == 0) address = BW'($urandom_range(LAST));
    else                                  address = addr_fr;
    model_update(rs, cont, n);
  endtask

  task automatic idle(input int k, input bit glitch);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 0, glitch);
  endtask

  // Run a full acquisition: restart, then enough cycles to align and finish.
  task automatic acquire(input bit cont, input int n, input int extra);
    step(1'b1, cont, n, 1'b0);
    idle(SPAN + 2 + SPAN * ((n == 0) ? 1 : n) + extra, 1'b0);
  endtask

  // Monitor: compares each DUT event against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missed_event: %s expected at cycle %0d, not seen by cycle %0d",
                 e.is_done ? "done" : "wen", e.cyc, cyc);
      end
      if (wen || done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: wen=%0b done=%0b count=%0d at cycle %0d, none expected",
                   wen, done, count, cyc);
        end else begin
          e = sb.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("wen", 32'(wen), 32'(!e.is_done));
          check("done", 32'(done), 32'(e.is_done));
          check("count", 32'(count), e.e_count);
          check("sweep_idx", 32'(sweep_idx), e.e_idx);
          check("init", 32'(init), 32'(e.e_init));
          check("first_sweep", 32'(first_sweep), 32'(e.e_first));
          check("busy", 32'(busy), 32'(!e.is_done));
        end
      end else begin
        check("init_outside_write", 32'(init), 0);
        check("first_outside_write", 32'(first_sweep), 0);
      end
    end
  end

  initial begin
    int guard;
    int target;
    aresetn    = 1'b0;
    restart    = 1'b0;
    continuous = 1'b0;
    n_sweeps   = '0;
    address    = '0;
    #2;
    check("rst_wen", 32'(wen), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_init", 32'(init), 0);
    check("rst_count", 32'(count), 0);
    check("rst_sweep_idx", 32'(sweep_idx), 0);
    idle(3, 1'b0);
    #2 aresetn = 1'b1;
    idle(20, 1'b0);   // address passes LAST while IDLE: nothing expected

    // Single sweep, then hold values after done.
    acquire(1'b0, 1, 4);
    check("hold_count", 32'(count), LAST);
    check("hold_idx_1", 32'(sweep_idx), 0);
    check("idle_busy", 32'(busy), 0);

    // Three back-to-back sweeps.
    acquire(1'b0, 3, 4);
    check("hold_idx_3", 32'(sweep_idx), 2);

    // n_sweeps = 0 behaves as one sweep.
    acquire(1'b0, 0, 4);

    // Continuous, two-sweep cycle; restart mid-sweep, then re-align.
    step(1'b1, 1'b1, 2, 1'b0);
    idle(SPAN + 2 + 5 * SPAN, 1'b0);
    idle($urandom_range(SPAN - 1), 1'b0);
    step(1'b1, 1'b1, 2, 1'b0);
    idle(SPAN + 2 + 3 * SPAN, 1'b0);

    // Restart in the final count == LAST cycle of a single-shot run.
    step(1'b1, 1'b0, 2, 1'b0);
    guard = 0;
    while (!active && guard < 4 * SPAN) begin
      step(1'b0, 1'b0, 0, 1'b0);
      guard++;
    end
    check("late_restart_armed", 32'(active), 1);
    target = wstart + 2 * SPAN - 1;
    guard = 0;
    while (cyc + 1 < target && guard < 8 * SPAN) begin
      step(1'b0, 1'b0, 0, 1'b0);
      guard++;
    end
    step(1'b1, 1'b0, 1, 1'b0);
    check("late_restart_count", 32'(count), LAST);
    idle(2, 1'b0);
    check("late_restart_busy", 32'(busy), 1);
    idle(2 * SPAN + 4, 1'b0);

    // Randomized acquisitions with glitching addresses and early restarts.
    for (int it = 0; it < 24; it++) begin
      step(1'b1, 1'($urandom_range(1)), int'($urandom_range(3)), 1'b1);
      idle(int'($urandom_range(10, 90)), 1'b1);
    end

    // Asynchronous reset while writing count 7.
    step(1'b1, 1'b0, 1, 1'b0);
    guard = 0;
    while (!(active && cyc == wstart + 7) && guard < 8 * SPAN) begin
      step(1'b0, 1'b0, 0, 1'b0);
      guard++;
    end
    check("areset_at_count7", 32'(count), 7);
    #2 aresetn = 1'b0;
    sb.delete();
    active   = 1'b0;
    scanning = 1'b0;
    #1;
    check("areset_wen", 32'(wen), 0);
    check("areset_init", 32'(init), 0);
    check("areset_busy", 32'(busy), 0);
    check("areset_count", 32'(count), 0);
    idle(2, 1'b0);
    #2 aresetn = 1'b1;
    idle(2 * SPAN, 1'b0);
    check("post_reset_idle_busy", 32'(busy), 0);
    check("post_reset_idle_wen", 32'(wen), 0);

    // Flush: cancel anything pending and let the monitor drain.
    step(1'b1, 1'b0, 1, 1'b0);
    idle(2, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
